// File: rtl/cam_pkg.sv
// Shared types and helpers for the DVP camera capture path.
package cam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_ACTIVE   = 2'd2
  } cam_state_e;

  // FIFO payload layout, MSB first: {sof, eol, y, x, rgb}
  localparam int RGB_W  = 24;
  localparam int FLAG_W = 2;

  // RGB565 -> RGB888 by replicating the top bits into the new LSBs
  function automatic logic [23:0] rgb565_to_rgb888(input logic [15:0] p);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = p[15:11];
    g = p[10:5];
    b = p[4:0];
    return {r, r[4:2], g, g[5:4], b, b[4:2]};
  endfunction

endpackage

// File: rtl/cam_pix_fifo.sv
// Small synchronous FIFO; a push while full is accepted when a pop frees a slot
// in the same cycle. DEPTH must be a power of two (>=2).
module cam_pix_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wptr, rptr;
  logic [AW:0]                 count;
  logic                        do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Head reads as zero when empty so the outputs are clean out of reset.
  assign rdata   = empty ? '0 : mem[rptr];

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/cam_dvp_capture.sv
// DVP camera capture: oversampled pclk/vsync/href/data, RGB565 byte pairs to
// tagged RGB888 pixels, delivered through a small ready/valid FIFO.
module cam_dvp_capture
  import cam_pkg::*;
#(
  parameter int X_BITS      = 12,
  parameter int Y_BITS      = 12,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_d,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [23:0]       pix_rgb,
  output logic [X_BITS-1:0] pix_x,
  output logic [Y_BITS-1:0] pix_y,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              overflow,
  output logic              line_len_err
);
  localparam int PAY_W = FLAG_W + Y_BITS + X_BITS + RGB_W;

  // synchronizer chains
  logic [SYNC_STAGES-1:0]       pclk_sr, vs_sr, hr_sr;
  logic [SYNC_STAGES-1:0][7:0]  d_sr;
  logic                         pclk_s, vs_s, hr_s;
  logic [7:0]                   d_s;
  logic                         pclk_q, vs_q, hr_q;
  logic                         pclk_rise, vs_fall, vs_rise, hr_fall;

  cam_state_e state, state_nx;

  // assembly / held pixel
  logic              phase;
  logic [7:0]        byte0;
  logic [X_BITS-1:0] x_cnt;
  logic [Y_BITS-1:0] y_cnt;
  logic              sof_pend;
  logic              held_vld, held_sof;
  logic [23:0]       held_rgb;
  logic [X_BITS-1:0] held_x;
  logic [Y_BITS-1:0] held_y;

  logic              byte_stb, px_new, sof_start, frame_end;
  logic              push, push_eol, pop, fifo_full, fifo_empty;
  logic [PAY_W-1:0]  push_data, fifo_rdata;

  assign pclk_s = pclk_sr[SYNC_STAGES-1];
  assign vs_s   = vs_sr[SYNC_STAGES-1];
  assign hr_s   = hr_sr[SYNC_STAGES-1];
  assign d_s    = d_sr[SYNC_STAGES-1];

  assign pclk_rise = pclk_s & ~pclk_q;
  assign vs_fall   = ~vs_s & vs_q;
  assign vs_rise   = vs_s & ~vs_q;
  assign hr_fall   = ~hr_s & hr_q;

  assign byte_stb  = (state == ST_ACTIVE) & pclk_rise & hr_s;
  assign px_new    = byte_stb & phase;
  assign sof_start = (state == ST_WAIT_SOF) & enable & vs_fall;
  assign frame_end = (state == ST_ACTIVE) & vs_rise;

  // Camera inputs are asynchronous: run them all through equal-depth chains
  // and keep one extra sample for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      pclk_sr <= '0;
      vs_sr   <= '0;
      hr_sr   <= '0;
      d_sr    <= '0;
      pclk_q  <= 1'b0;
      vs_q    <= 1'b0;
      hr_q    <= 1'b0;
    end else begin
      pclk_sr <= {pclk_sr[SYNC_STAGES-2:0], cam_pclk};
      vs_sr   <= {vs_sr[SYNC_STAGES-2:0], cam_vsync};
      hr_sr   <= {hr_sr[SYNC_STAGES-2:0], cam_href};
      d_sr    <= {d_sr[SYNC_STAGES-2:0], cam_d};
      pclk_q  <= pclk_s;
      vs_q    <= vs_s;
      hr_q    <= hr_s;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next state: arm on enable, start at vsync fall, close at vsync rise.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     if (enable) state_nx = ST_WAIT_SOF;
      ST_WAIT_SOF: begin
        if (!enable)      state_nx = ST_IDLE;
        else if (vs_fall) state_nx = ST_ACTIVE;
      end
      ST_ACTIVE:   if (vs_rise) state_nx = enable ? ST_WAIT_SOF : ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  // The held pixel goes to the FIFO when the next one replaces it (eol=0)
  // or when the line/frame closes (eol=1).
  always_comb begin
    push     = 1'b0;
    push_eol = 1'b0;
    if (state == ST_ACTIVE && held_vld) begin
      if (px_new) begin
        push = 1'b1;
      end else if (hr_fall || vs_rise) begin
        push     = 1'b1;
        push_eol = 1'b1;
      end
    end
  end

  assign push_data = {held_sof, push_eol, held_y, held_x, held_rgb};
  assign pop       = pix_valid & pix_ready;

  // Byte pairing, coordinates, held pixel, frame/status bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase        <= 1'b0;
      byte0        <= '0;
      x_cnt        <= '0;
      y_cnt        <= '0;
      sof_pend     <= 1'b0;
      held_vld     <= 1'b0;
      held_sof     <= 1'b0;
      held_rgb     <= '0;
      held_x       <= '0;
      held_y       <= '0;
      frame_done   <= 1'b0;
      frame_count  <= '0;
      overflow     <= 1'b0;
      line_len_err <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (sof_start) begin
        x_cnt    <= '0;
        y_cnt    <= '0;
        phase    <= 1'b0;
        held_vld <= 1'b0;
        sof_pend <= 1'b1;
      end
      if (byte_stb) begin
        if (!phase) begin
          byte0 <= d_s;
          phase <= 1'b1;
        end else begin
          phase    <= 1'b0;
          held_vld <= 1'b1;
          held_rgb <= rgb565_to_rgb888({byte0, d_s});
          held_x   <= x_cnt;
          held_y   <= y_cnt;
          held_sof <= sof_pend;
          sof_pend <= 1'b0;
          if (x_cnt != '1) x_cnt <= x_cnt + X_BITS'(1);
        end
      end
      if (state == ST_ACTIVE && hr_fall) begin
        held_vld <= 1'b0;
        x_cnt    <= '0;
        y_cnt    <= y_cnt + Y_BITS'(1);
        phase    <= 1'b0;
        if (phase) line_len_err <= 1'b1;
      end
      if (frame_end) begin
        held_vld    <= 1'b0;
        phase       <= 1'b0;
        sof_pend    <= 1'b0;
        frame_count <= frame_count + 16'd1;
      end
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  cam_pix_fifo #(
    .WIDTH (PAY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pix_valid = ~fifo_empty;
  assign {pix_sof, pix_eol, pix_y, pix_x, pix_rgb} = fifo_rdata;

endmodule

// File: tb/tb_cam_dvp_capture.sv
// Bench for cam_dvp_capture: DVP waveform generator, expected-pixel queue,
// independent output monitor.
module tb_cam_dvp_capture;
  localparam int XB   = 3;   // narrow x so saturation shows up in short lines
  localparam int YB   = 12;
  localparam int XMAX = (1 << XB) - 1;

  logic          clk = 1'b0;
  logic          reset, enable, cam_pclk, cam_vsync, cam_href;
  logic [7:0]    cam_d;
  logic          pix_valid, pix_ready;
  logic [23:0]   pix_rgb;
  logic [XB-1:0] pix_x;
  logic [YB-1:0] pix_y;
  logic          pix_sof, pix_eol, frame_done, overflow, line_len_err;
  logic [15:0]   frame_count;

  cam_dvp_capture #(.X_BITS(XB), .Y_BITS(YB), .SYNC_STAGES(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cam_pclk(cam_pclk),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_d(cam_d),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_rgb(pix_rgb),
    .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .frame_done(frame_done), .frame_count(frame_count),
    .overflow(overflow), .line_len_err(line_len_err));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0]   rgb;
    logic [XB-1:0] x;
    logic [YB-1:0] y;
    logic          sof;
    logic          eol;
  } pix_t;

  pix_t        exp_q[$];
  int          tests = 0, fails = 0;
  int          ready_mode = 0;     // 0: always ready, 1: random, 2: stalled
  bit          ignore_out = 1'b1;
  int          fd_cnt = 0, exp_fd = 0;
  logic [15:0] exp_fc = '0;
  int          lb[$];
  int          drop_after = -1, abort_line = -1, abort_byte = -1;
  bit          fixed_mode = 1'b1;
  logic [7:0]  fb0, fb1;

  // Reference colour expansion written as plain arithmetic.
  function automatic logic [23:0] model_rgb(input logic [7:0] b0, input logic [7:0] b1);
    int r5, g6, b5, r8, g8, b8;
    r5 = int'(b0) / 8;
    g6 = (int'(b0) % 8) * 8 + int'(b1) / 32;
    b5 = int'(b1) % 32;
    r8 = r5 * 8 + r5 / 4;
    g8 = g6 * 4 + g6 / 16;
    b8 = b5 * 8 + b5 / 4;
    return 24'(r8 * 65536 + g8 * 256 + b8);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One camera byte period: 2 clk low, 3 clk high (pclk = clk/5).
  task automatic send_byte(input logic [7:0] b, input logic h);
    cam_pclk = 1'b0; cam_d = b; cam_href = h;
    tick(2);
    cam_pclk = 1'b1;
    tick(3);
  endtask

  task automatic mid_reset();
    ignore_out = 1'b1;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid valid", pix_valid, 0);
    chk("rst_mid data", {pix_rgb, pix_x, pix_y, pix_sof, pix_eol}, 0);
    chk("rst_mid status", {frame_count, overflow, line_len_err, frame_done}, 0);
    exp_q.delete();
    exp_fc = '0;
    ignore_out = 1'b0;
    @(posedge clk); #1;
  endtask

  // Drives one frame from lb[]; records the pixels the spec says should
  // come out (first `keep` of them) when on=1.
  task automatic drive_frame(input bit on, input int keep);
    int kept, px, nb;
    bit first;
    logic [7:0] b, b0;
    cam_vsync = 1'b1;
    repeat (3) send_byte(8'h00, 1'b0);
    cam_vsync = 1'b0;
    repeat (2) send_byte(8'h00, 1'b0);
    kept = 0; first = 1'b1; b0 = '0;
    for (int l = 0; l < lb.size(); l++) begin
      nb = lb[l]; px = 0;
      for (int i = 0; i < nb; i++) begin
        if (fixed_mode) b = (i % 2 == 0) ? fb0 : fb1;
        else            b = 8'($urandom_range(0, 255));
        if (i % 2 == 0) b0 = b;
        else begin
          if (on && kept < keep) begin
            exp_q.push_back('{rgb: model_rgb(b0, b), x: XB'(px > XMAX ? XMAX : px),
                              y: YB'(l), sof: first, eol: (px == nb / 2 - 1)});
            kept++;
          end
          first = 1'b0;
          px++;
        end
        send_byte(b, 1'b1);
        if (l == abort_line && i == abort_byte) begin
          mid_reset();
          on = 1'b0;
        end
      end
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      if (l == drop_after) enable = 1'b0;
    end
    cam_vsync = 1'b1;
    repeat (3) send_byte(8'h00, 1'b0);
    if (on) begin exp_fd++; exp_fc++; end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) tick(1);
    chk(name, exp_q.size(), 0);
  endtask

  // Consumer: only this process drives pix_ready.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = 1'($urandom_range(0, 1));
      default: pix_ready = 1'b0;
    endcase
  end

  // Output monitor: compares every accepted pixel, checks head stability.
  pix_t cur, prev_head, e;
  bit   hold_chk = 1'b0;
  always @(negedge clk) begin
    cur = {pix_rgb, pix_x, pix_y, pix_sof, pix_eol};
    if (!ignore_out && pix_valid) begin
      if (hold_chk) begin
        tests++;
        if (cur !== prev_head) begin
          fails++;
          $display("FAIL head_stable: got %h expected %h", cur, prev_head);
        end
      end
      if (pix_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pixel: got %h expected none", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            fails++;
            $display("FAIL pixel: got rgb=%h x=%0d y=%0d sof=%b eol=%b expected rgb=%h x=%0d y=%0d sof=%b eol=%b",
                     cur.rgb, cur.x, cur.y, cur.sof, cur.eol, e.rgb, e.x, e.y, e.sof, e.eol);
          end
        end
      end
    end
    hold_chk  = !ignore_out && pix_valid && !pix_ready && !reset;
    prev_head = cur;
  end

  // frame_done: count pulses and check they are one cycle wide.
  logic fd_prev = 1'b0;
  always @(negedge clk) begin
    if (frame_done) begin
      fd_cnt++;
      tests++;
      if (fd_prev) begin
        fails++;
        $display("FAIL frame_done_width: got 2+ cycles expected 1");
      end
    end
    fd_prev = frame_done;
  end

  initial begin
    reset = 1'b1; enable = 1'b0; cam_pclk = 1'b0; cam_vsync = 1'b0;
    cam_href = 1'b0; cam_d = '0;
    tick(3);
    reset = 1'b0;
    @(negedge clk);
    chk("reset valid", pix_valid, 0);
    chk("reset rgb", pix_rgb, 0);
    chk("reset xy", {pix_x, pix_y}, 0);
    chk("reset flags", {pix_sof, pix_eol, frame_done}, 0);
    chk("reset frame_count", frame_count, 0);
    chk("reset sticky", {overflow, line_len_err}, 0);
    @(posedge clk); #1;
    ignore_out = 1'b0;
    enable = 1'b1;
    tick(4);

    // 4x2 red frame
    fixed_mode = 1'b1; fb0 = 8'hF8; fb1 = 8'h00;
    lb = '{8, 8};
    drive_frame(1'b1, 1000);
    wait_drain("drain red");
    chk("frame_count 4x2", frame_count, exp_fc);
    chk("frame_done count 4x2", fd_cnt, exp_fd);

    // green and blue
    fb0 = 8'h07; fb1 = 8'hE0; lb = '{4};
    drive_frame(1'b1, 1000);
    fb0 = 8'h00; fb1 = 8'h1F;
    drive_frame(1'b1, 1000);
    wait_drain("drain green/blue");

    // random content, random backpressure, x saturation on long lines
    fixed_mode = 1'b0; ready_mode = 1;
    for (int f = 0; f < 3; f++) begin
      lb.delete();
      for (int l = 0; l < 4; l++) lb.push_back(2 * $urandom_range(1, 12));
      drive_frame(1'b1, 1000);
    end
    ready_mode = 0;
    wait_drain("drain random");
    chk("frame_count random", frame_count, exp_fc);
    chk("overflow clear", overflow, 0);

    // consumer stalled through a 16-pixel line
    ready_mode = 2; lb = '{32};
    drive_frame(1'b1, 4);
    @(negedge clk);
    chk("overflow set", overflow, 1);
    chk("valid held while stalled", pix_valid, 1);
    @(posedge clk); #1;
    ready_mode = 0;
    wait_drain("drain after stall");

    // odd byte count on a line
    chk("line_len_err clear", line_len_err, 0);
    lb = '{3, 4};
    drive_frame(1'b1, 1000);
    wait_drain("drain odd line");
    chk("line_len_err set", line_len_err, 1);

    // reset in the middle of a line, then a clean frame
    lb = '{8, 8}; abort_line = 0; abort_byte = 4;
    drive_frame(1'b1, 1000);
    abort_line = -1; abort_byte = -1;
    lb = '{4, 4};
    drive_frame(1'b1, 1000);
    wait_drain("drain after reset");
    chk("frame_count after reset", frame_count, exp_fc);

    // enable dropped mid-frame: frame finishes, next frame ignored
    lb = '{4, 4}; drop_after = 0;
    drive_frame(1'b1, 1000);
    drop_after = -1;
    drive_frame(1'b0, 1000);
    tick(50);
    chk("queue empty at end", exp_q.size(), 0);
    chk("frame_count final", frame_count, exp_fc);
    chk("frame_done total", fd_cnt, exp_fd);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
